// File: rtl/tnn_neuron_acc36.sv
// tnn_neuron_acc36 -- ternary-neuron back end for a pair of 36-input popcount units.
// Accumulates (pc_pos - pc_neg) over up to MAX_WORDS words, then thresholds the
// saturated sum into a ternary activation {-1, 0, +1} held until consumed.
// Optional feature: define TNN_ACC_PC_CLAMP_EN to clamp each popcount to 36
// before the subtraction, which bounds the error of overshooting approximate units.

module tnn_neuron_acc36 #(
   parameter int MAX_WORDS = 8,
   parameter int ACC_W     = 10,
   parameter int THR_HI    = 4,
   parameter int THR_LO    = -4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_pc_pos,
   input  logic [5:0]       in_pc_neg,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_act,
   output logic [ACC_W-1:0] out_sum,
   output logic [7:0]       out_words,
   output logic             err_len
);

   typedef enum logic {
      StAcc = 1'b0,
      StOut = 1'b1
   } state_t;

   localparam logic [ACC_W-1:0]        AccMax = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0]        AccMin = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] ThrHi  = ACC_W'(THR_HI);
   localparam logic signed [ACC_W-1:0] ThrLo  = ACC_W'(THR_LO);
   localparam logic [7:0]              WordLimit = 8'(MAX_WORDS);

   state_t           state_q, state_d;
   logic             inReady_q, inReady_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [1:0]       act_q, act_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [7:0]       words_q, words_d;
   logic             err_q, err_d;

   logic [5:0]       pcPos, pcNeg;
   logic [6:0]       diff;
   logic [ACC_W:0]   sumWide;
   logic [ACC_W-1:0] satSum;
   logic [7:0]       cntInc;
   logic             accept;
   logic             finalBeat;

   // Popcount conditioning, signed difference and saturating accumulate of one beat
   always_comb begin
`ifdef TNN_ACC_PC_CLAMP_EN
      pcPos = (in_pc_pos > 6'd36) ? 6'd36 : in_pc_pos;
      pcNeg = (in_pc_neg > 6'd36) ? 6'd36 : in_pc_neg;
`else
      pcPos = in_pc_pos;
      pcNeg = in_pc_neg;
`endif
      diff    = {1'b0, pcPos} - {1'b0, pcNeg};
      sumWide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-6){diff[6]}}, diff};
      if (sumWide[ACC_W] != sumWide[ACC_W-1]) begin
         satSum = sumWide[ACC_W] ? AccMin : AccMax;
      end else begin
         satSum = sumWide[ACC_W-1:0];
      end
      cntInc    = cnt_q + 8'd1;
      accept    = in_valid && inReady_q;
      finalBeat = in_last || (cntInc == WordLimit);
   end

   // Next-state logic: accumulate in ACC, latch the result on a final beat, release in OUT
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      sum_d   = sum_q;
      words_d = words_q;
      err_d   = err_q;
      unique case (state_q)
         StAcc: begin
            if (accept) begin
               acc_d = satSum;
               cnt_d = cntInc;
               if (finalBeat) begin
                  state_d = StOut;
                  sum_d   = satSum;
                  words_d = cntInc;
                  if ($signed(satSum) >= ThrHi) begin
                     act_d = 2'b01;
                  end else if ($signed(satSum) <= ThrLo) begin
                     act_d = 2'b11;
                  end else begin
                     act_d = 2'b00;
                  end
                  if (!in_last) begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         StOut: begin
            if (out_ready) begin
               state_d = StAcc;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = StAcc;
      endcase
      inReady_d = (state_d == StAcc);
   end

   // State and datapath registers; reset drops any partial sum or pending result at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StAcc;
         inReady_q <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         act_q     <= 2'b00;
         sum_q     <= '0;
         words_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         inReady_q <= inReady_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         act_q     <= act_d;
         sum_q     <= sum_d;
         words_q   <= words_d;
         err_q     <= err_d;
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = (state_q == StOut);
   assign out_act   = act_q;
   assign out_sum   = sum_q;
   assign out_words = words_q;
   assign err_len   = err_q;

endmodule

// File: tb/tb_tnn_neuron_acc36.sv
// Directed testbench for tnn_neuron_acc36: default instance plus a narrow
// instance (ACC_W = 8, MAX_WORDS = 4) that can reach accumulator saturation.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_tnn_neuron_acc36;

   logic       clk = 1'b0;
   logic       rst;
   logic       inValid, inReady, inLast, outValid, outReady, errLen;
   logic [5:0] pcPos, pcNeg;
   logic [1:0] outAct;
   logic [9:0] outSum;
   logic [7:0] outWords;

   logic       v2, ready2, last2, ovalid2, oready2, err2;
   logic [5:0] pos2, neg2;
   logic [1:0] act2;
   logic [7:0] sum2;
   logic [7:0] words2;

   int passCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   tnn_neuron_acc36 dut (
      .clk(clk), .rst(rst),
      .in_valid(inValid), .in_ready(inReady),
      .in_pc_pos(pcPos), .in_pc_neg(pcNeg), .in_last(inLast),
      .out_valid(outValid), .out_ready(outReady),
      .out_act(outAct), .out_sum(outSum), .out_words(outWords),
      .err_len(errLen)
   );

   tnn_neuron_acc36 #(.MAX_WORDS(4), .ACC_W(8), .THR_HI(4), .THR_LO(-4)) dutSat (
      .clk(clk), .rst(rst),
      .in_valid(v2), .in_ready(ready2),
      .in_pc_pos(pos2), .in_pc_neg(neg2), .in_last(last2),
      .out_valid(ovalid2), .out_ready(oready2),
      .out_act(act2), .out_sum(sum2), .out_words(words2),
      .err_len(err2)
   );

   // One comparison: counts it, and on a miss reports tag, observed and expected
   task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Wait (bounded) for in_ready on the main instance, then present one beat for one edge
   task automatic applyStimulus(input logic [5:0] p, input logic [5:0] n, input logic last);
      int waited = 0;
      while (inReady !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("ready_before_beat", 32'(inReady), 32'sd1);
      pcPos   = p;
      pcNeg   = n;
      inLast  = last;
      inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   // Check the held result of the main instance
   task automatic checkResult(input string tag, input int sum, input int act,
                              input int words, input int err);
      checkOutput({tag, "_valid"}, 32'(outValid), 32'sd1);
      checkOutput({tag, "_sum"}, 32'($signed(outSum)), sum);
      checkOutput({tag, "_act"}, 32'(outAct), act);
      checkOutput({tag, "_words"}, 32'(outWords), words);
      checkOutput({tag, "_err"}, 32'(errLen), err);
   endtask

   // Consume the pending result with out_ready for one edge
   task automatic consume();
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      checkOutput("consume_valid_low", 32'(outValid), 32'sd0);
      checkOutput("consume_ready_high", 32'(inReady), 32'sd1);
   endtask

   initial begin
      rst = 1'b1;
      inValid = 1'b0; inLast = 1'b0; outReady = 1'b0; pcPos = '0; pcNeg = '0;
      v2 = 1'b0; last2 = 1'b0; oready2 = 1'b0; pos2 = '0; neg2 = '0;
      repeat (2) @(negedge clk);

      checkOutput("rst_in_ready", 32'(inReady), 32'sd0);
      checkOutput("rst_out_valid", 32'(outValid), 32'sd0);
      checkOutput("rst_out_act", 32'(outAct), 32'sd0);
      checkOutput("rst_out_sum", 32'(outSum), 32'sd0);
      checkOutput("rst_out_words", 32'(outWords), 32'sd0);
      checkOutput("rst_err_len", 32'(errLen), 32'sd0);

      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_ready", 32'(inReady), 32'sd1);

      // single word 10 - 3 = 7
      applyStimulus(6'd10, 6'd3, 1'b1);
      checkResult("single", 7, 1, 1, 0);
      checkOutput("single_ready_low", 32'(inReady), 32'sd0);
      consume();

      // three words: 0, -2, -1 -> -3
      applyStimulus(6'd5, 6'd5, 1'b0);
      checkOutput("mid_no_valid", 32'(outValid), 32'sd0);
      applyStimulus(6'd2, 6'd4, 1'b0);
      applyStimulus(6'd1, 6'd2, 1'b1);
      checkResult("three", -3, 0, 3, 0);
      consume();

      // overshooting popcount
      applyStimulus(6'd63, 6'd0, 1'b1);
`ifdef TNN_ACC_PC_CLAMP_EN
      checkResult("pc63", 36, 1, 1, 0);
`else
      checkResult("pc63", 63, 1, 1, 0);
`endif
      consume();

      // word limit without in_last: 8 x (-20) = -160
      for (int i = 0; i < 8; i++) begin
         applyStimulus(6'd0, 6'd20, 1'b0);
      end
      checkResult("limit", -160, 3, 8, 1);
      consume();
      checkOutput("limit_err_sticky", 32'(errLen), 32'sd1);

      // back-pressure with in_valid held high
      applyStimulus(6'd3, 6'd0, 1'b1);
      pcPos = 6'd20; pcNeg = 6'd0; inLast = 1'b1; inValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_ready_low", 32'(inReady), 32'sd0);
         checkOutput("bp_valid_high", 32'(outValid), 32'sd1);
         checkOutput("bp_sum_hold", 32'($signed(outSum)), 32'sd3);
         checkOutput("bp_words_hold", 32'(outWords), 32'sd1);
      end
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      checkOutput("bp_release_ready", 32'(inReady), 32'sd1);
      checkOutput("bp_release_valid", 32'(outValid), 32'sd0);
      @(negedge clk);
      inValid = 1'b0; inLast = 1'b0;
      checkResult("bp_next", 20, 1, 1, 1);
      consume();

      // reset in the middle of an accumulation
      applyStimulus(6'd4, 6'd0, 1'b0);
      applyStimulus(6'd2, 6'd0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_ready", 32'(inReady), 32'sd0);
      checkOutput("midrst_valid", 32'(outValid), 32'sd0);
      checkOutput("midrst_err", 32'(errLen), 32'sd0);
      checkOutput("midrst_sum", 32'(outSum), 32'sd0);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(6'd9, 6'd1, 1'b1);
      checkResult("after_rst", 8, 1, 1, 0);
      consume();

      // saturation on the narrow instance (8-bit accumulator, 4-word limit)
      pos2 = 6'd63; neg2 = 6'd0; last2 = 1'b0; v2 = 1'b1;
      repeat (4) @(negedge clk);
      v2 = 1'b0;
      checkOutput("sat_pos_valid", 32'(ovalid2), 32'sd1);
      checkOutput("sat_pos_sum", 32'($signed(sum2)), 32'sd127);
      checkOutput("sat_pos_act", 32'(act2), 32'sd1);
      checkOutput("sat_pos_words", 32'(words2), 32'sd4);
      checkOutput("sat_pos_err", 32'(err2), 32'sd1);
      oready2 = 1'b1;
      @(negedge clk);
      oready2 = 1'b0;
      checkOutput("sat_ready_back", 32'(ready2), 32'sd1);
      pos2 = 6'd0; neg2 = 6'd63; last2 = 1'b0; v2 = 1'b1;
      repeat (3) @(negedge clk);
      last2 = 1'b1;
      @(negedge clk);
      v2 = 1'b0; last2 = 1'b0;
      checkOutput("sat_neg_sum", 32'($signed(sum2)), -32'sd128);
      checkOutput("sat_neg_act", 32'(act2), 32'sd3);
      checkOutput("sat_neg_words", 32'(words2), 32'sd4);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/tnn_neuron_acc36.md
# tnn_neuron_acc36

Sequential ternary-neuron back end that sits directly downstream of a pair of 36-input popcount units (positive-weight and negative-weight lanes). Each beat accepts the two 6-bit popcounts of one 36-bit input word and accumulates their signed difference over a multi-word neuron fan-in. On the last word it thresholds the sum into a ternary activation {-1, 0, +1}. The 6-bit popcount inputs may come from approximate units, so values up to 63 are legal on the ports.

## Interface
- `MAX_WORDS`, 8: maximum number of words per neuron evaluation; range 1..255.
- `ACC_W`, 10: accumulator width, signed two's complement.
- `THR_HI`, 4: signed threshold; `sum >= THR_HI` produces +1.
- `THR_LO`, -4: signed threshold; `sum <= THR_LO` produces -1. Requires `THR_LO < THR_HI`.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  popcount beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_pc_pos`  in  6  popcount of the positive-weight lane.
- `in_pc_neg`  in  6  popcount of the negative-weight lane.
- `in_last`  in  1  beat is the final word of this neuron.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_act`  out  2  ternary activation: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
- `out_sum`  out  ACC_W  final signed accumulator value.
- `out_words`  out  8  number of words accumulated for this result.
- `err_len`  out  1  sticky flag: a word limit was hit without `in_last`.

## Operation
- There are two states, ACC and OUT. Reset enters ACC.
- In ACC, `in_ready` = 1 and `out_valid` = 0.
- A beat is accepted when `in_valid && in_ready`. On acceptance:
  - d = pc_pos − pc_neg, a 7-bit signed value in [-63, 63].
  - The d is sign-extended to ACC_W bits and added to `acc`.
  - The addition saturates at [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - `cnt` increments.
- The beat is final if `in_last` = 1, or if `cnt+1 == MAX_WORDS`.
  - If the beat is final because of the word limit and `in_last` = 0, `err_len` is set. It stays set until reset.
- On a final beat, the block registers the following and moves to OUT:
  - `out_sum` = new acc
  - `out_words` = cnt+1
  - `out_act` = +1 if `out_sum >= THR_HI`, else -1 if `out_sum <= THR_LO`, else 0
- In OUT, `in_ready` = 0 and `out_valid` = 1. `out_act`, `out_sum` and `out_words` are held stable.
- When `out_ready` = 1 in OUT:
  - The result is consumed.
  - `acc` and `cnt` clear to 0.
  - The state returns to ACC.
- Input beats with `in_valid` = 0 change nothing. Gaps between words are allowed.
- `in_pc_*` values are only sampled on accepted beats.

## Timing
- Reset values:
  - `in_ready` = 0 while `rst` is high, then 1 from the first cycle after deassertion.
  - `out_valid` = 0, `out_act` = 2'b00, `out_sum` = 0, `out_words` = 0, `err_len` = 0.
  - Internal `acc` = 0, `cnt` = 0.
- Latency: a final beat accepted at edge N gives `out_valid` = 1 after edge N, i.e. 1 cycle.
- Throughput: one word per cycle during ACC. There is one bubble cycle per neuron: `in_ready` is low for at least one cycle while in OUT.
- Back-pressure: while `out_ready` = 0, OUT holds indefinitely. No input is accepted.
- If `out_ready` is held at 1, OUT lasts exactly 1 cycle and `in_ready` returns on the following cycle.
- `in_ready` is a registered function of state only. It has no combinational path from `in_valid` or `out_ready`.
- Reset mid-operation: asserting `rst` at any point discards a partial accumulation or a pending result immediately. The block returns to ACC with all outputs at their reset values.
- With MAX_WORDS = 1, every beat is final. A beat with `in_last` = 0 then sets `err_len`.

## Configuration
- Macro: `TNN_ACC_PC_CLAMP_EN`.
- When defined, each of `in_pc_pos` and `in_pc_neg` is clamped to 36 before the subtraction, so d ∈ [-36, 36]. This bounds the error from approximate popcounts that overshoot.
- When undefined, raw 6-bit values are used, so d ∈ [-63, 63].
- All other behaviour is identical in both configurations.

## Test plan
- Single-word neuron, pos = 10, neg = 3, `in_last` = 1. Required: one cycle later `out_valid` = 1, `out_sum` = 7, `out_act` = 2'b01, `out_words` = 1, `err_len` = 0.
- Three words (5,5), (2,4), (1,2) with `in_last` on the third. Required: `out_sum` = -3, `out_act` = 2'b00, `out_words` = 3.
- Single word pos = 63, neg = 0, `in_last` = 1. Required: `out_sum` = 36 with `TNN_ACC_PC_CLAMP_EN` defined, 63 without it. `out_act` = 2'b01 in both cases.
- Eight words of (0,20), all with `in_last` = 0 (MAX_WORDS = 8). Required: result issued after the 8th beat with `out_sum` = -160, `out_act` = 2'b11, `out_words` = 8, and `err_len` = 1, still 1 after the result is consumed.
- Hold `out_ready` = 0 for 5 cycles after a result while `in_valid` = 1. Required: `in_ready` = 0 and the outputs stay stable throughout. Raising `out_ready` gives `in_ready` = 1 on the next cycle, and the next neuron starts from `acc` = 0.
- Assert `rst` after two accepted words, then send (9,1) with `in_last` = 1. Required: the earlier words are discarded, `out_sum` = 8, `out_words` = 1.
